fmdll_ratio_ctrl: RTL
=====================

Name: fmdll_ratio_ctrl

Overview:
Upstream configuration sequencer for the fractional multiplying DLL, clocked by the external reference clock.
- Accepts a requested ratio (M, N) over a valid/ready handshake.
- Drives M/N and a DLL reset into the DLL, then times the relock sequence.
- Watches the DLL's 2-bit Sel status to report lock, loss of lock, and lock timeout.

Parameters:
RST_CYC, 4, cycles dll_rst_n is held low after a ratio change (>=1)
SETTLE_CYC, 8, cycles after DLL reset release before Sel is checked (>=1)
STABLE_CYC, 16, consecutive cycles of unchanged synchronized Sel required for lock (>=1)
TIMEOUT_CYC, 64, maximum cycles in CHECK before declaring failure (>STABLE_CYC)
CW, 16, width of the internal counters; every cycle parameter must be < 2^CW

Ports:
clk_ext  input  1  reference clock; all logic is on its rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  ratio request valid
req_M  input  2  requested divider M
req_N  input  4  requested multiplier N
req_ready  output  1  request can be accepted this cycle
Sel_in  input  2  DLL Sel status, asynchronous to this block
M  output  2  registered M to DLL
N  output  4  registered N to DLL
dll_rst_n  output  1  active-low DLL reset, registered
locked  output  1  DLL lock indication
fail  output  1  lock timeout indication (level)
err  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; M=2'b01; N=4'b0001; dll_rst_n=0.
  - locked=0; fail=0; err=0; req_ready=1.
  - All counters and synchronizer flops = 0.
- Sel_in passes through a 2-flop synchronizer (sel_s). A third flop (sel_q) holds the previous sel_s. A Sel "change" means sel_s != sel_q.
- req_ready=1 in IDLE, LOCKED and FAIL; 0 in HOLD, SETTLE and CHECK.
- A request is accepted when req_valid and req_ready are both high at a rising edge. req_valid while req_ready=0 is ignored; it is not queued.
- Invalid request (req_M==0 or req_N==0), if accepted:
  - err=1 for exactly the next cycle.
  - State, M, N, locked and fail are unchanged.
- Valid request accepted at edge t:
  - At edge t, M/N load the request.
  - Also at edge t: dll_rst_n=0, locked=0, fail=0, state=HOLD, counter=0.
- HOLD:
  - The counter increments each cycle.
  - After RST_CYC cycles (edge t+RST_CYC): dll_rst_n=1, state=SETTLE, counter=0.
- SETTLE:
  - After SETTLE_CYC cycles: state=CHECK; stable counter and timeout counter cleared.
- CHECK:
  - The timeout counter increments every cycle.
  - The stable counter increments when sel_s==sel_q and clears to 0 on a change.
  - When the stable counter reaches STABLE_CYC, at that edge: state=LOCKED, locked=1.
  - Otherwise, when the timeout counter reaches TIMEOUT_CYC: state=FAIL, fail=1.
  - If both conditions hit on the same edge, lock wins.
- Lock timing with Sel constant: locked rises at edge t+RST_CYC+SETTLE_CYC+STABLE_CYC.
- LOCKED:
  - A Sel change clears locked at the same edge and returns to CHECK with both counters cleared. dll_rst_n stays 1.
  - A valid request restarts the sequence from HOLD; this takes priority over a simultaneous Sel change.
- FAIL:
  - fail stays 1 and dll_rst_n stays 1 until a new valid request or reset.
  - A valid request clears fail and enters HOLD.
- Counters saturate and never wrap.
- M/N change only on acceptance of a valid request.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rst_n assertion in any state returns every output to its reset value immediately. Sequencing resumes only on a new request after rst_n deasserts.

Test Plan:
Use the default parameters and hold Sel_in=2'b00 unless stated.
1. Reset release, then req M=2, N=5 accepted at edge t → M=2, N=5 at t. dll_rst_n=0 over t..t+3 and 1 from t+4. req_ready=0 from t. locked=1 exactly at edge t+28; req_ready=1 at t+28.
2. Request M=0, N=3 while IDLE → err=1 for one cycle. M=1, N=1, state, locked and fail unchanged. A following request M=1, N=0 gives the same result.
3. Valid request, then toggle Sel_in every 10 cycles from dll_rst_n release → locked never rises. fail=1 at edge t+4+8+64. req_ready=1 in FAIL. A new valid request clears fail.
4. LOCKED, then Sel_in changes to 2'b01 → locked drops 3 edges later (2 synchronizer edges + 1). With Sel held, locked reasserts 16 cycles after re-entering CHECK. dll_rst_n remains 1 throughout.
5. req_valid pulsed during HOLD, SETTLE and CHECK → ignored and M/N unchanged. A request in LOCKED (M=3, N=9) restarts HOLD, loads the new M/N and drops locked at the same edge.
6. rst_n pulsed low mid-SETTLE, asynchronous to clk_ext → all outputs take reset values without waiting for a clock edge. State is IDLE after rst_n deasserts, and no relock occurs until a new request.

Source files
------------

// File: rtl/fmdll_ratio_ctrl.sv
// Ratio configuration sequencer for the fractional multiplying DLL: accepts M/N
// requests, pulses the DLL reset, then qualifies lock from the synchronized Sel status.
module fmdll_ratio_ctrl #(
   parameter int unsigned RST_CYC     = 4,
   parameter int unsigned SETTLE_CYC  = 8,
   parameter int unsigned STABLE_CYC  = 16,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned CW          = 16
) (
   input  logic       clk_ext,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [1:0] req_M,
   input  logic [3:0] req_N,
   output logic       req_ready,
   input  logic [1:0] Sel_in,
   output logic [1:0] M,
   output logic [3:0] N,
   output logic       dll_rst_n,
   output logic       locked,
   output logic       fail,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_SETTLE,
      S_CHECK,
      S_LOCKED,
      S_FAIL
   } state_t;

   localparam logic [CW-1:0] RST_LIM    = CW'(RST_CYC);
   localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_CYC);
   localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_CYC);
   localparam logic [CW-1:0] TMO_LIM    = CW'(TIMEOUT_CYC);
   localparam logic [CW-1:0] ONE        = CW'(1);

   state_t        state_q, state_d;
   logic [1:0]    sel_m, sel_s, sel_q;
   logic [CW-1:0] cnt_q, cnt_d, stab_q, stab_d, tmo_q, tmo_d;
   logic [CW-1:0] cnt_inc, stab_inc, tmo_inc;
   logic [1:0]    m_d;
   logic [3:0]    n_d;
   logic          drst_d, locked_d, fail_d, err_d, ready_d;
   logic          accept, req_ok, sel_chg;

   assign accept  = req_valid && req_ready;
   assign req_ok  = (req_M != 2'b00) && (req_N != 4'b0000);
   assign sel_chg = (sel_s != sel_q);

   // Saturating increments so no counter can ever wrap back to a match value.
   assign cnt_inc  = (cnt_q  == '1) ? cnt_q  : cnt_q  + ONE;
   assign stab_inc = (stab_q == '1) ? stab_q : stab_q + ONE;
   assign tmo_inc  = (tmo_q  == '1) ? tmo_q  : tmo_q  + ONE;

   always_comb begin
      state_d  = state_q;
      m_d      = M;
      n_d      = N;
      drst_d   = dll_rst_n;
      locked_d = locked;
      fail_d   = fail;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      stab_d   = stab_q;
      tmo_d    = tmo_q;

      case (state_q)
         S_HOLD: begin
            if (cnt_inc == RST_LIM) begin
               state_d = S_SETTLE;
               drst_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_SETTLE: begin
            if (cnt_inc == SETTLE_LIM) begin
               state_d = S_CHECK;
               stab_d  = '0;
               tmo_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_CHECK: begin
            tmo_d  = tmo_inc;
            stab_d = sel_chg ? '0 : stab_inc;
            // Lock is tested first so it wins a same-edge tie with the timeout.
            if (stab_d == STABLE_LIM) begin
               state_d  = S_LOCKED;
               locked_d = 1'b1;
            end else if (tmo_d == TMO_LIM) begin
               state_d = S_FAIL;
               fail_d  = 1'b1;
            end
         end
         S_LOCKED: begin
            if (sel_chg) begin
               state_d  = S_CHECK;
               locked_d = 1'b0;
               stab_d   = '0;
               tmo_d    = '0;
            end
         end
         default: ;
      endcase

      // Acceptance overrides the per-state update, including a Sel change in LOCKED.
      if (accept) begin
         if (req_ok) begin
            state_d  = S_HOLD;
            m_d      = req_M;
            n_d      = req_N;
            drst_d   = 1'b0;
            locked_d = 1'b0;
            fail_d   = 1'b0;
            cnt_d    = '0;
         end else begin
            err_d = 1'b1;
         end
      end

      ready_d = (state_d == S_IDLE) || (state_d == S_LOCKED) || (state_d == S_FAIL);
   end

   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_m     <= '0;
         sel_s     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         stab_q    <= '0;
         tmo_q     <= '0;
         M         <= 2'b01;
         N         <= 4'b0001;
         dll_rst_n <= 1'b0;
         locked    <= 1'b0;
         fail      <= 1'b0;
         err       <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         state_q   <= state_d;
         sel_m     <= Sel_in;
         sel_s     <= sel_m;
         sel_q     <= sel_s;
         cnt_q     <= cnt_d;
         stab_q    <= stab_d;
         tmo_q     <= tmo_d;
         M         <= m_d;
         N         <= n_d;
         dll_rst_n <= drst_d;
         locked    <= locked_d;
         fail      <= fail_d;
         err       <= err_d;
         req_ready <= ready_d;
      end
   end

endmodule
